// File: rtl/score_keeper.sv
// Game-state sequencer and 3-digit BCD score / high-score keeper for the dino VGA game.
// Every output is a register; the score advances one point every TICK_DIV cycles while running.
module score_keeper #(
    parameter int TICK_DIV = 5000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       collision,
    output logic       running,
    output logic       game_over,
    output logic       point_tick,
    output logic [3:0] score_u,
    output logic [3:0] score_t,
    output logic [3:0] score_h,
    output logic [3:0] hi_u,
    output logic [3:0] hi_t,
    output logic [3:0] hi_h,
    output logic       new_high
);

    localparam int TW = $clog2(TICK_DIV);
    localparam logic [TW-1:0] TERM = TW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        OVER
    } state_t;

    state_t        state;
    logic [TW-1:0] timer;
    logic [11:0]   score;
    logic [11:0]   hi;

    // Digits are packed {hundreds, tens, units}; 999 is the ceiling.
    function automatic logic [11:0] bcd_inc(input logic [11:0] d);
        logic [3:0] h;
        logic [3:0] t;
        logic [3:0] u;
        {h, t, u} = d;
        if (d == 12'h999) begin
            return d;
        end
        if (u != 4'd9) begin
            u = u + 4'd1;
        end else begin
            u = 4'd0;
            if (t != 4'd9) begin
                t = t + 4'd1;
            end else begin
                t = 4'd0;
                h = h + 4'd1;
            end
        end
        return {h, t, u};
    endfunction

    function automatic logic bcd_gt(input logic [11:0] a, input logic [11:0] b);
        if (a[11:8] != b[11:8]) begin
            return a[11:8] > b[11:8];
        end
        if (a[7:4] != b[7:4]) begin
            return a[7:4] > b[7:4];
        end
        return a[3:0] > b[3:0];
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            timer      <= '0;
            score      <= '0;
            hi         <= '0;
            running    <= 1'b0;
            game_over  <= 1'b0;
            point_tick <= 1'b0;
            new_high   <= 1'b0;
        end else begin
            point_tick <= 1'b0;
            case (state)
                IDLE: begin
                    timer <= '0;
                    if (start && !collision) begin
                        score   <= '0;
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                RUN: begin
                    // A collision outranks a coincident terminal count: the point is lost.
                    if (collision) begin
                        state     <= OVER;
                        running   <= 1'b0;
                        game_over <= 1'b1;
                        if (bcd_gt(score, hi)) begin
                            hi       <= score;
                            new_high <= 1'b1;
                        end
                    end else if (timer == TERM) begin
                        timer      <= '0;
                        score      <= bcd_inc(score);
                        point_tick <= 1'b1;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                OVER: begin
                    // No restart while still overlapping the obstacle.
                    if (start && !collision) begin
                        score     <= '0;
                        timer     <= '0;
                        new_high  <= 1'b0;
                        state     <= RUN;
                        running   <= 1'b1;
                        game_over <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    timer     <= '0;
                    running   <= 1'b0;
                    game_over <= 1'b0;
                end
            endcase
        end
    end

    assign score_h = score[11:8];
    assign score_t = score[7:4];
    assign score_u = score[3:0];
    assign hi_h    = hi[11:8];
    assign hi_t    = hi[7:4];
    assign hi_u    = hi[3:0];

endmodule

// File: tb/tb_score_keeper.sv
// Scoreboard bench for score_keeper: an integer-arithmetic game model predicts every cycle's outputs,
// and a negedge monitor pops and compares them against the DUT.
module tb_score_keeper;

    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       collision;
    logic       running;
    logic       game_over;
    logic       point_tick;
    logic       new_high;
    logic [3:0] score_u, score_t, score_h;
    logic [3:0] hi_u, hi_t, hi_h;

    score_keeper #(.TICK_DIV(TD)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .collision  (collision),
        .running    (running),
        .game_over  (game_over),
        .point_tick (point_tick),
        .score_u    (score_u),
        .score_t    (score_t),
        .score_h    (score_h),
        .hi_u       (hi_u),
        .hi_t       (hi_t),
        .hi_h       (hi_h),
        .new_high   (new_high)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    logic [27:0] exp_q[$];
    logic [27:0] mon_exp;

    // Game model: 0 idle, 1 run, 2 over; scores are plain integers.
    int m_state = 0;
    int m_timer = 0;
    int m_score = 0;
    int m_hi    = 0;
    bit m_nh    = 1'b0;
    bit m_pt    = 1'b0;

    function automatic logic [11:0] bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [27:0] model_outputs();
        return {m_state == 1, m_state == 2, m_pt, m_nh, bcd(m_score), bcd(m_hi)};
    endfunction

    function automatic logic [27:0] dut_outputs();
        return {running, game_over, point_tick, new_high,
                score_h, score_t, score_u, hi_h, hi_t, hi_u};
    endfunction

    task automatic model_step(input bit r, input bit s, input bit c);
        m_pt = 1'b0;
        if (r) begin
            m_state = 0; m_timer = 0; m_score = 0; m_hi = 0; m_nh = 1'b0;
        end else if (m_state == 0) begin
            m_timer = 0;
            if (s && !c) begin
                m_score = 0; m_state = 1;
            end
        end else if (m_state == 1) begin
            if (c) begin
                m_state = 2;
                if (m_score > m_hi) begin
                    m_hi = m_score; m_nh = 1'b1;
                end
            end else if (m_timer == TD - 1) begin
                m_timer = 0;
                if (m_score < 999) m_score++;
                m_pt = 1'b1;
            end else begin
                m_timer++;
            end
        end else begin
            if (s && !c) begin
                m_score = 0; m_timer = 0; m_nh = 1'b0; m_state = 1;
            end
        end
    endtask

    task automatic step(input bit r, input bit s, input bit c);
        reset = r;
        start = s;
        collision = c;
        model_step(r, s, c);
        exp_q.push_back(model_outputs());
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h, want %h", name, $time, act, req);
        end
    endtask

    task automatic run_ticks(input int n, input bit s);
        int got = 0;
        int lim = n * TD + 2 * TD;
        while (got < n && lim > 0) begin
            step(1'b0, s, 1'b0);
            if (m_pt) got++;
            lim--;
        end
        vectors++;
        if (got < n) begin
            miscompares++;
            $display("FAIL run_ticks at %0t: got %0d ticks, want %0d", $time, got, n);
        end
    endtask

    task automatic wait_terminal();
        int lim = 2 * TD;
        while (m_timer != TD - 1 && lim > 0) begin
            step(1'b0, 1'b0, 1'b0);
            lim--;
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            vectors++;
            if (dut_outputs() !== mon_exp) begin
                miscompares++;
                $display("FAIL cycle_outputs at %0t: got %h, want %h", $time, dut_outputs(), mon_exp);
            end
        end
    end

    initial begin
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        chk("reset_state", 32'(dut_outputs()), 32'h0);

        // Game 1: ends at 005 with a collision on the terminal count.
        step(1'b0, 1'b1, 1'b0);
        chk("running_after_start", 32'(running), 32'h1);
        repeat (12) step(1'b0, 1'b0, 1'b0);
        chk("score_after_12", 32'({score_h, score_t, score_u}), 32'h003);
        run_ticks(2, 1'b0);
        wait_terminal();
        step(1'b0, 1'b0, 1'b1);
        chk("coincident_tick", 32'(point_tick), 32'h0);
        chk("coincident_over", 32'(game_over), 32'h1);
        chk("g1_score", 32'({score_h, score_t, score_u}), 32'h005);
        chk("g1_hi", 32'({hi_h, hi_t, hi_u}), 32'h005);
        chk("g1_new_high", 32'(new_high), 32'h1);

        repeat (3) step(1'b0, 1'b1, 1'b1);
        chk("over_start_in_obstacle", 32'({running, game_over}), 32'h1);

        // Game 2: lower score keeps the high score.
        step(1'b0, 1'b1, 1'b0);
        chk("g2_restart", 32'({running, new_high, score_h, score_t, score_u}), 32'h2000);
        run_ticks(3, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        chk("g2_hi", 32'({hi_h, hi_t, hi_u}), 32'h005);
        chk("g2_new_high", 32'(new_high), 32'h0);

        // Game 3: equal score is not a new high.
        step(1'b0, 1'b1, 1'b0);
        run_ticks(5, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        chk("g3_new_high", 32'(new_high), 32'h0);

        // Game 4: digit carries and saturation.
        step(1'b0, 1'b1, 1'b0);
        run_ticks(9, 1'b0);
        chk("score_009", 32'({score_h, score_t, score_u}), 32'h009);
        run_ticks(1, 1'b0);
        chk("score_010", 32'({point_tick, score_h, score_t, score_u}), 32'h1010);
        run_ticks(988, 1'b0);
        chk("score_998", 32'({score_h, score_t, score_u}), 32'h998);
        repeat (3) begin
            run_ticks(1, 1'b1);
            chk("saturated", 32'({point_tick, score_h, score_t, score_u}), 32'h1999);
        end
        step(1'b0, 1'b0, 1'b1);
        chk("g4_hi", 32'({new_high, hi_h, hi_t, hi_u}), 32'h1999);

        // Game 5: start held throughout, reset mid-run at 042.
        step(1'b0, 1'b1, 1'b0);
        run_ticks(42, 1'b1);
        chk("score_042", 32'({score_h, score_t, score_u}), 32'h042);
        step(1'b1, 1'b1, 1'b0);
        chk("reset_mid_run", 32'(dut_outputs()), 32'h0);

        repeat (600) begin
            step($urandom_range(0, 199) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0);
        end

        step(1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        #1;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/score_keeper.md
Name: score_keeper

Overview:
- Game-state and score source for the dino VGA design.
- Runs the IDLE/RUN/OVER game sequence from the start button and the collision flag.
- Counts the running score as 3 BCD digits and latches a high score.
- Presents all digits to the number-rendering blocks, which consume them as their counter inputs.

Parameters:
TICK_DIV, 5000000, clock cycles per score point (must be >= 2)

Ports:
clk  input  1  system pixel clock
reset  input  1  synchronous, active-high reset
start  input  1  level from debounced jump button; sampled every cycle
collision  input  1  dino/obstacle overlap flag from the collision logic
running  output  1  1 while in RUN
game_over  output  1  1 while in OVER
point_tick  output  1  one-cycle pulse in the cycle the score digits update
score_u  output  4  running score units digit, BCD
score_t  output  4  running score tens digit, BCD
score_h  output  4  running score hundreds digit, BCD
hi_u  output  4  high score units digit, BCD
hi_t  output  4  high score tens digit, BCD
hi_h  output  4  high score hundreds digit, BCD
new_high  output  1  1 in OVER when the last game set a new high score

Behaviour:
- All outputs are registered. Clock is clk only. Reset is synchronous and active-high.
- Reset, at any state including mid-RUN:
  - state IDLE; timer 0.
  - all score and hi digits 0.
  - running, game_over, point_tick and new_high all 0.
- States: IDLE, RUN, OVER. running = (state==RUN); game_over = (state==OVER).
- IDLE:
  - timer held at 0; score held.
  - start=1 and collision=0 -> score and timer cleared, next state RUN.
  - running=1 in the cycle after start is sampled.
- RUN:
  - timer increments each cycle.
  - When timer==TICK_DIV-1: timer<=0, score increments by 1, point_tick=1 for that one cycle.
  - First point arrives TICK_DIV cycles after entering RUN.
  - start is ignored.
- BCD increment:
  - units 9 -> 0 with carry into tens; tens 9 -> 0 with carry into hundreds.
  - Saturates at 999: score holds at 999 and timer still wraps.
  - point_tick still pulses at 999.
  - Digits are never outside 0..9.
- Collision in RUN (collision=1):
  - next state OVER; timer frozen.
  - Collision wins over a coincident terminal count: no increment and no point_tick in that cycle.
- High-score latch on the RUN->OVER transition:
  - If score > hi (compare hundreds, then tens, then units): hi digits <= score digits and new_high <= 1.
  - Otherwise hi is unchanged and new_high stays 0.
  - Equal scores do not set new_high.
- OVER:
  - score, hi and timer held; collision ignored.
  - start=1 and collision=0 -> score cleared, timer cleared, new_high cleared, next state RUN.
  - start=1 while collision=1 is ignored, so the game does not restart inside the obstacle.
- start is level-sensitive. Holding start from IDLE through RUN has no extra effect.
- The hi digits survive every restart and are cleared only by reset.

Test Plan:
- TICK_DIV=4, reset, one-cycle start -> running=1 the next cycle; point_tick every 4 cycles; after 12 cycles in RUN, score = 0/0/3.
- Run to 9 points, then 1 more -> units 9->0, tens 0->1; score_h/t/u = 0/1/0 on the cycle point_tick=1.
- Force score to 998 and run 3 more ticks -> 999 held; point_tick still pulses each tick.
- Collision asserted in the same cycle timer==TICK_DIV-1 -> no increment, point_tick=0, game_over=1 the next cycle.
- Game 1 ends at 0/0/5 (hi becomes 005, new_high=1); restart, game 2 ends at 0/0/3 -> hi stays 005, new_high=0; game 3 ends at 0/0/5 -> new_high=0.
- In OVER, start with collision=1 -> stays in OVER. Reset asserted mid-RUN at score 0/4/2 -> all digits 0 and state IDLE on the next cycle.
